gshare_branch_predictor: RTL and testbench
==========================================

// Module: gshare_branch_predictor
// PURPOSE
//  Parametrised gshare direction predictor for B-type branches: PC xor global history indexes a table of
//  saturating counters. GHR is updated speculatively at fetch and repaired on mispredict/flush.
//  Sits beside the IF stage. Caller carries the pred_ghr snapshot down the pipe and returns it at EX.
//  Adds saturating performance counters for branches and mispredicts.
// PARAMETERS
//  GHR_WIDTH   8   global history bits; must satisfy 2 <= GHR_WIDTH <= INDEX_WIDTH
//  INDEX_WIDTH 8   table index bits; table depth = 2**INDEX_WIDTH
//  CNT_WIDTH   2   per-entry counter width; must be >= 2
//  CNT_INIT    1   counter reset value (weakly not-taken for CNT_WIDTH=2)
//  STAT_WIDTH  16  width of each performance counter
// PORTS
//  clk                 in   1            clock
//  rst_n               in   1            synchronous active-low reset
//  PL_stall            in   1            pipeline stall; freezes all state updates
//  PL_flush            in   1            pipeline flush; suppresses the speculative GHR shift
//  pred_valid          in   1            B-type instruction in IF this cycle
//  pred_pc             in   32           PC of the IF instruction
//  pred_taken          out  1            predicted direction (combinational)
//  pred_ghr            out  GHR_WIDTH    GHR snapshot before this prediction (combinational)
//  resolve_valid       in   1            B-type resolved in EX this cycle
//  resolve_pc          in   32           PC of the resolved branch
//  resolve_ghr         in   GHR_WIDTH    pred_ghr snapshot carried with that branch
//  resolve_taken       in   1            actual direction
//  resolve_mispredict  in   1            actual direction != predicted direction
//  recover_valid       in   1            non-branch flush (e.g. jalr) needs a GHR restore
//  recover_ghr         in   GHR_WIDTH    GHR value to restore
//  perf_branches       out  STAT_WIDTH   count of resolved branches
//  perf_mispredicts    out  STAT_WIDTH   count of resolved mispredicts
// BEHAVIOUR
//  - Index: idx = pc[INDEX_WIDTH+1:2] ^ {zero-pad, ghr}. Fetch uses pred_pc and the live GHR.
//    Resolve uses resolve_pc and resolve_ghr.
//  - pred_taken = MSB of table[idx_f]; zero latency. It is driven even when pred_valid=0; the caller ignores it then.
//  - pred_ghr equals the GHR register value.
//  - All updates happen at posedge, and only when rst_n=1 and PL_stall=0.
//  - Counter update when resolve_valid=1: table[idx_r] +1 if resolve_taken, else -1.
//    Saturates at 0 and at 2**CNT_WIDTH-1.
//  - GHR next-value priority (highest first):
//      reset -> 0
//      resolve_valid & resolve_mispredict -> {resolve_ghr[GHR_WIDTH-2:0], resolve_taken}
//      recover_valid -> recover_ghr
//      pred_valid & !PL_flush -> {ghr[GHR_WIDTH-2:0], pred_taken}
//      otherwise hold
//  - Same-cycle fetch and resolve on the same entry: fetch sees the old counter (no bypass).
//    The write lands at the edge.
//  - perf_branches increments on each counted resolve. perf_mispredicts increments when resolve_mispredict=1.
//    Both saturate at all-ones and never wrap.
//  - Reset: every table entry = CNT_INIT, GHR = 0, perf counters = 0.
//    Reset is applied by a full-table loop in one cycle.
//    Reset asserted mid-operation discards pending updates that cycle.
//  - PL_stall=1 with resolve_valid=1: no update. The caller holds resolve_* until the stall drops,
//    and the update happens exactly once.
//  - resolve_mispredict with resolve_valid=0 is ignored.
// TESTING
//  - Reset, then pred_pc=0x100, pred_valid=1 -> pred_taken=0, pred_ghr=0x00; next cycle ghr=0x00.
//  - Resolve pc=0x100, ghr=0, taken=1, twice -> entry 0x40 = 3. A third resolve stays at 3 (saturation).
//    Fetch of 0x100 with ghr=0 -> pred_taken=1.
//  - Speculative shift: three fetches predicting 1,0,1 -> ghr=0x05.
//    Mispredict resolve with ghr=0x01, taken=0 in the same cycle as a fetch -> ghr=0x02 (mispredict wins).
//  - recover_valid=1, recover_ghr=0xA5, PL_flush=1, pred_valid=1 -> ghr=0xA5, no shift.
//  - PL_stall=1 for 3 cycles with resolve_valid=1 -> counters, GHR and perf unchanged.
//    On release: exactly one update, perf_branches +1.
//  - STAT_WIDTH=4: 20 mispredicting resolves -> perf_mispredicts=15 and perf_branches=15, both held.

Source files
------------

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: (PC xor global history) indexes a table of saturating counters.
// Latency: prediction is combinational in IF; counter, GHR and perf updates land at the next posedge.
// Backpressure: PL_stall freezes every state update; the caller holds resolve_* until the stall drops.
module gshare_branch_predictor #(
  parameter int GHR_WIDTH   = 8,
  parameter int INDEX_WIDTH = 8,
  parameter int CNT_WIDTH   = 2,
  parameter int CNT_INIT    = 1,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PL_stall,
  input  logic                   PL_flush,
  input  logic                   pred_valid,
  input  logic [31:0]            pred_pc,
  output logic                   pred_taken,
  output logic [GHR_WIDTH-1:0]   pred_ghr,
  input  logic                   resolve_valid,
  input  logic [31:0]            resolve_pc,
  input  logic [GHR_WIDTH-1:0]   resolve_ghr,
  input  logic                   resolve_taken,
  input  logic                   resolve_mispredict,
  input  logic                   recover_valid,
  input  logic [GHR_WIDTH-1:0]   recover_ghr,
  output logic [STAT_WIDTH-1:0]  perf_branches,
  output logic [STAT_WIDTH-1:0]  perf_mispredicts
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_RST  = CNT_WIDTH'(CNT_INIT);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0]  table_q [DEPTH];
  logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
  logic [STAT_WIDTH-1:0] branches_q, branches_d;
  logic [STAT_WIDTH-1:0] mispredicts_q, mispredicts_d;

  logic [INDEX_WIDTH-1:0] idx_f, idx_r;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_d;
  logic                   resolve_fire;

  // PC bits outside the index field do not participate in the hash.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:INDEX_WIDTH+2], pred_pc[1:0],
                            resolve_pc[31:INDEX_WIDTH+2], resolve_pc[1:0]};

  // History is narrower than or equal to the index, so it is zero-extended into the xor.
  assign idx_f = pred_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
  assign idx_r = resolve_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(resolve_ghr);

  // Fetch reads the pre-edge counter; a same-cycle resolve write is not bypassed.
  assign pred_taken = table_q[idx_f][CNT_WIDTH-1];
  assign pred_ghr   = ghr_q;

  assign resolve_fire     = resolve_valid && !PL_stall;
  assign cnt_r            = table_q[idx_r];
  assign perf_branches    = branches_q;
  assign perf_mispredicts = mispredicts_q;

  // Saturating +1/-1 of the resolved entry toward the actual direction.
  always_comb begin
    cnt_d = cnt_r;
    if (resolve_taken) begin
      if (cnt_r != CNT_MAX) cnt_d = cnt_r + 1'b1;
    end else begin
      if (cnt_r != '0) cnt_d = cnt_r - 1'b1;
    end
  end

  // GHR next value: mispredict repair beats non-branch recovery beats the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (resolve_valid && resolve_mispredict) begin
      ghr_d = {resolve_ghr[GHR_WIDTH-2:0], resolve_taken};
    end else if (recover_valid) begin
      ghr_d = recover_ghr;
    end else if (pred_valid && !PL_flush) begin
      ghr_d = {ghr_q[GHR_WIDTH-2:0], pred_taken};
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (resolve_valid && branches_q != STAT_MAX) begin
      branches_d = branches_q + 1'b1;
    end
    if (resolve_valid && resolve_mispredict && mispredicts_q != STAT_MAX) begin
      mispredicts_d = mispredicts_q + 1'b1;
    end
  end

  // Counter table: whole table reinitialised in one reset cycle, single write port otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= CNT_RST;
      end
    end else if (resolve_fire) begin
      table_q[idx_r] <= cnt_d;
    end
  end

  // GHR and perf registers; a stall holds everything, reset discards pending updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q         <= '0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (!PL_stall) begin
      ghr_q         <= ghr_d;
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: default instance plus a STAT_WIDTH=4 instance on shared stimulus.
// Inputs change 1 time unit after posedge; outputs are checked mid-cycle.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PL_stall, PL_flush;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        resolve_valid, resolve_taken, resolve_mispredict;
  logic [31:0] resolve_pc;
  logic [7:0]  resolve_ghr;
  logic        recover_valid;
  logic [7:0]  recover_ghr;

  logic        pred_taken, pred_taken_s;
  logic [7:0]  pred_ghr, pred_ghr_s;
  logic [15:0] perf_branches, perf_mispredicts;
  logic [3:0]  perf_branches_s, perf_mispredicts_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gshare_branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .PL_flush(PL_flush),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_ghr(resolve_ghr),
    .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
    .recover_valid(recover_valid), .recover_ghr(recover_ghr),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  gshare_branch_predictor #(.STAT_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .PL_flush(PL_flush),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken_s), .pred_ghr(pred_ghr_s),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_ghr(resolve_ghr),
    .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
    .recover_valid(recover_valid), .recover_ghr(recover_ghr),
    .perf_branches(perf_branches_s), .perf_mispredicts(perf_mispredicts_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PL_stall = 0; PL_flush = 0; pred_valid = 0; pred_pc = 32'h0;
    resolve_valid = 0; resolve_pc = 32'h0; resolve_ghr = 8'h0;
    resolve_taken = 0; resolve_mispredict = 0;
    recover_valid = 0; recover_ghr = 8'h0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [7:0] g, input logic t, input logic m);
    resolve_valid = 1; resolve_pc = pc; resolve_ghr = g; resolve_taken = t; resolve_mispredict = m;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;

    // Reset state and first fetch
    pred_valid = 1; pred_pc = 32'h100; #1;
    check("rst_ghr", 32'(pred_ghr), 32'h00);
    check("rst_perf_b", 32'(perf_branches), 32'd0);
    check("rst_perf_m", 32'(perf_mispredicts), 32'd0);
    check("rst_entry40", 32'(dut.table_q[8'h40]), 32'd1);
    check("rst_pred", 32'(pred_taken), 32'd0);
    tick();
    check("fetch0_ghr", 32'(pred_ghr), 32'h00);

    // Train entry 0x40 up to saturation
    idle();
    resolve(32'h100, 8'h00, 1'b1, 1'b0);
    tick();
    check("train1", 32'(dut.table_q[8'h40]), 32'd2);
    tick();
    check("train2", 32'(dut.table_q[8'h40]), 32'd3);
    tick();
    check("train_sat", 32'(dut.table_q[8'h40]), 32'd3);
    check("train_perf_b", 32'(perf_branches), 32'd3);
    check("train_ghr", 32'(pred_ghr), 32'h00);
    idle();
    pred_valid = 1; pred_pc = 32'h100; #1;
    check("trained_pred", 32'(pred_taken), 32'd1);

    // Restore GHR to 0 then fetch predicting 1,0,1
    idle();
    recover_valid = 1; recover_ghr = 8'h00;
    tick();
    idle();
    pred_valid = 1; pred_pc = 32'h100; #1;
    check("shift_p1", 32'(pred_taken), 32'd1);
    tick();
    pred_pc = 32'h200; #1;
    check("shift_p2", 32'(pred_taken), 32'd0);
    tick();
    pred_pc = 32'h108; #1;
    check("shift_p3", 32'(pred_taken), 32'd1);
    tick();
    check("shift_ghr", 32'(pred_ghr), 32'h05);

    // Mispredict repair wins over a concurrent fetch
    pred_pc = 32'h100;
    resolve(32'h300, 8'h01, 1'b0, 1'b1);
    tick();
    check("mp_ghr", 32'(pred_ghr), 32'h02);
    check("mp_entryC1", 32'(dut.table_q[8'hC1]), 32'd0);
    check("mp_perf_b", 32'(perf_branches), 32'd4);
    check("mp_perf_m", 32'(perf_mispredicts), 32'd1);

    // Recovery under flush, then flush alone suppresses the shift
    idle();
    recover_valid = 1; recover_ghr = 8'hA5; PL_flush = 1; pred_valid = 1; pred_pc = 32'h100;
    tick();
    check("recover_ghr", 32'(pred_ghr), 32'hA5);
    recover_valid = 0;
    tick();
    check("flush_hold", 32'(pred_ghr), 32'hA5);

    // Stall freezes everything for three cycles
    idle();
    PL_stall = 1; pred_valid = 1; pred_pc = 32'h100;
    resolve(32'h100, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_ghr", 32'(pred_ghr), 32'hA5);
      check("stall_entry", 32'(dut.table_q[8'h40]), 32'd3);
      check("stall_perf_b", 32'(perf_branches), 32'd4);
      check("stall_perf_m", 32'(perf_mispredicts), 32'd1);
    end
    PL_stall = 0;
    tick();
    check("unstall_entry", 32'(dut.table_q[8'h40]), 32'd2);
    check("unstall_perf_b", 32'(perf_branches), 32'd5);
    check("unstall_perf_m", 32'(perf_mispredicts), 32'd2);
    check("unstall_ghr", 32'(pred_ghr), 32'h00);
    idle();
    tick();
    check("once_entry", 32'(dut.table_q[8'h40]), 32'd2);
    check("once_perf_b", 32'(perf_branches), 32'd5);

    // Mispredict flag without resolve_valid is ignored
    resolve_mispredict = 1; resolve_ghr = 8'h33;
    tick();
    check("ign_ghr", 32'(pred_ghr), 32'h00);
    check("ign_perf_m", 32'(perf_mispredicts), 32'd2);

    // Counter saturates at zero
    idle();
    resolve(32'h300, 8'h01, 1'b0, 1'b0);
    tick();
    check("sat0_entry", 32'(dut.table_q[8'hC1]), 32'd0);
    check("sat0_perf_b", 32'(perf_branches), 32'd6);

    // Same-cycle fetch and resolve on one entry: fetch sees the old counter
    idle();
    pred_valid = 1; pred_pc = 32'h100;
    resolve(32'h100, 8'h00, 1'b0, 1'b0); #1;
    check("nobypass_pred", 32'(pred_taken), 32'd1);
    tick();
    check("nobypass_entry", 32'(dut.table_q[8'h40]), 32'd1);
    check("nobypass_ghr", 32'(pred_ghr), 32'h01);
    idle();
    pred_valid = 1; pred_pc = 32'h104; #1;
    check("after_write_pred", 32'(pred_taken), 32'd0);

    // Reset mid-operation discards the pending update
    idle();
    rst_n = 0;
    resolve(32'h100, 8'h00, 1'b1, 1'b1);
    pred_valid = 1; pred_pc = 32'h100;
    tick();
    check("midrst_entry", 32'(dut.table_q[8'h40]), 32'd1);
    check("midrst_ghr", 32'(pred_ghr), 32'h00);
    check("midrst_perf_b", 32'(perf_branches), 32'd0);
    check("midrst_perf_m", 32'(perf_mispredicts), 32'd0);
    idle();
    rst_n = 1;

    // Twenty mispredicting resolves: 4-bit stats saturate, 16-bit keep counting
    resolve(32'h100, 8'h00, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) tick();
    idle();
    tick();
    check("sat_s_perf_m", 32'(perf_mispredicts_s), 32'd15);
    check("sat_s_perf_b", 32'(perf_branches_s), 32'd15);
    check("wide_perf_m", 32'(perf_mispredicts), 32'd20);
    check("wide_perf_b", 32'(perf_branches), 32'd20);
    check("sat_entry", 32'(dut.table_q[8'h40]), 32'd3);
    check("sat_ghr", 32'(pred_ghr), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
